// File: rtl/jtag_wb_pkg.sv
// jtag_wb_pkg: shared field layout, status bit offsets and FSM encoding for jtag_wb_master.
//   host_cmd layout (MSB..LSB): {tgl, we, inc, sel[SEL_W], adr[AW], dat[DW]}
//   host_sts layout (MSB..LSB): {ack_tgl, busy, err, tmo, dat[DW]}
package jtag_wb_pkg;

   typedef enum logic [2:0] {
      RESYNC  = 3'd0,
      IDLE    = 3'd1,
      CAPTURE = 3'd2,
      BUS     = 3'd3,
      DONE    = 3'd4
   } state_t;

   // Status flag positions counted upward from the top of the data field.
   localparam int STS_TMO_OFS  = 0;
   localparam int STS_ERR_OFS  = 1;
   localparam int STS_BUSY_OFS = 2;
   localparam int STS_ACK_OFS  = 3;

   function automatic int sel_w(input int dw);
      return dw / 8;
   endfunction

   function automatic int cmd_w(input int aw, input int dw);
      return 3 + sel_w(dw) + aw + dw;
   endfunction

   function automatic int sts_w(input int dw);
      return 4 + dw;
   endfunction

   function automatic int cmd_adr_lsb(input int dw);
      return dw;
   endfunction

   function automatic int cmd_sel_lsb(input int aw, input int dw);
      return aw + dw;
   endfunction

   function automatic int cmd_inc_bit(input int aw, input int dw);
      return aw + dw + sel_w(dw);
   endfunction

   function automatic int cmd_we_bit(input int aw, input int dw);
      return cmd_inc_bit(aw, dw) + 1;
   endfunction

   function automatic int cmd_tgl_bit(input int aw, input int dw);
      return cmd_inc_bit(aw, dw) + 2;
   endfunction

   function automatic int sts_bit(input int dw, input int ofs);
      return dw + ofs;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser, both stages cleared by async active-low reset.
//   sys_clk, sys_rst_n : destination clock and reset
//   d                  : asynchronous input
//   q                  : synchronised output
module sync_2ff (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic d,
   output logic q
);
   logic meta;
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) {q, meta} <= 2'b00;
      else {q, meta} <= {meta, d};
endmodule

// File: rtl/jtag_wb_master.sv
// jtag_wb_master: toggle-handshake host command bus to Wishbone classic single-cycle master.
//   sys_clk, sys_rst_n : system clock, async active-low reset
//   host_cmd_i         : {tgl, we, inc, sel, adr, dat}, quasi-static, asynchronous to sys_clk
//   host_sts_o         : {ack_tgl, busy, err, tmo, dat}
//   wb_*               : Wishbone classic master interface
module jtag_wb_master
   import jtag_wb_pkg::*;
#(
   parameter  int ADDR_WIDTH     = 32,
   parameter  int DATA_WIDTH     = 32,
   parameter  int TIMEOUT_CYCLES = 1024,
   localparam int SEL_W          = sel_w(DATA_WIDTH),
   localparam int CMD_W          = cmd_w(ADDR_WIDTH, DATA_WIDTH),
   localparam int STS_W          = sts_w(DATA_WIDTH)
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic [CMD_W-1:0]      host_cmd_i,
   output logic [STS_W-1:0]      host_sts_o,
   output logic [ADDR_WIDTH-1:0] wb_adr_o,
   output logic [DATA_WIDTH-1:0] wb_dat_o,
   input  logic [DATA_WIDTH-1:0] wb_dat_i,
   output logic [SEL_W-1:0]      wb_sel_o,
   output logic                  wb_we_o,
   output logic                  wb_cyc_o,
   output logic                  wb_stb_o,
   input  logic                  wb_ack_i,
   input  logic                  wb_err_i
);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic                  cmd_we, cmd_inc, tgl_s;
   logic [SEL_W-1:0]      cmd_sel;
   logic [ADDR_WIDTH-1:0] cmd_adr, next_adr;
   logic [DATA_WIDTH-1:0] cmd_dat, res_dat, sts_dat;
   logic                  res_err, res_tmo, sts_err, sts_tmo, ack_tgl, busy;
   logic [1:0]            rcnt;
   logic [TW-1:0]         tcnt;
   state_t                state;

   assign cmd_we  = host_cmd_i[cmd_we_bit(ADDR_WIDTH, DATA_WIDTH)];
   assign cmd_inc = host_cmd_i[cmd_inc_bit(ADDR_WIDTH, DATA_WIDTH)];
   assign cmd_sel = host_cmd_i[cmd_sel_lsb(ADDR_WIDTH, DATA_WIDTH) +: SEL_W];
   assign cmd_adr = host_cmd_i[cmd_adr_lsb(DATA_WIDTH) +: ADDR_WIDTH];
   assign cmd_dat = host_cmd_i[0 +: DATA_WIDTH];

   assign host_sts_o = {ack_tgl, busy, sts_err, sts_tmo, sts_dat};

   sync_2ff u_tgl_sync (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .d         (host_cmd_i[cmd_tgl_bit(ADDR_WIDTH, DATA_WIDTH)]),
      .q         (tgl_s)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         state    <= RESYNC;
         rcnt     <= '0;
         tcnt     <= '0;
         ack_tgl  <= 1'b0;
         busy     <= 1'b0;
         next_adr <= '0;
         wb_adr_o <= '0;
         wb_dat_o <= '0;
         wb_sel_o <= '0;
         wb_we_o  <= 1'b0;
         wb_cyc_o <= 1'b0;
         wb_stb_o <= 1'b0;
         res_err  <= 1'b0;
         res_tmo  <= 1'b0;
         res_dat  <= '0;
         sts_err  <= 1'b0;
         sts_tmo  <= 1'b0;
         sts_dat  <= '0;
      end else
         case (state)
            // Wait until the synchroniser holds the live host toggle, then adopt it
            // as already acknowledged so a toggle left over from before reset is ignored.
            RESYNC: begin
               rcnt <= rcnt + 2'd1;
               if (rcnt == 2'd2) begin
                  ack_tgl <= tgl_s;
                  state   <= IDLE;
               end
            end
            IDLE:
               if (tgl_s != ack_tgl) begin
                  busy  <= 1'b1;
                  state <= CAPTURE;
               end
            CAPTURE: begin
               wb_we_o  <= cmd_we;
               wb_sel_o <= cmd_sel;
               wb_dat_o <= cmd_dat;
               wb_adr_o <= cmd_inc ? next_adr : cmd_adr;
               wb_cyc_o <= 1'b1;
               wb_stb_o <= 1'b1;
               tcnt     <= '0;
               state    <= BUS;
            end
            // err beats ack; ack beats an expiring timeout.
            BUS:
               if (wb_err_i || wb_ack_i || tcnt == T_LAST) begin
                  wb_cyc_o <= 1'b0;
                  wb_stb_o <= 1'b0;
                  res_err  <= wb_err_i;
                  res_tmo  <= !wb_err_i && !wb_ack_i;
                  res_dat  <= (wb_err_i || !wb_ack_i || wb_we_o) ? '0 : wb_dat_i;
                  state    <= DONE;
               end else
                  tcnt <= tcnt + 1'b1;
            DONE: begin
               sts_err  <= res_err;
               sts_tmo  <= res_tmo;
               sts_dat  <= res_dat;
               ack_tgl  <= !ack_tgl;
               busy     <= 1'b0;
               next_adr <= wb_adr_o + ADDR_WIDTH'(SEL_W);
               state    <= IDLE;
            end
            default: begin
               rcnt  <= '0;
               state <= RESYNC;
            end
         endcase

endmodule

// File: tb/tb_jtag_wb_master.sv
// tb_jtag_wb_master: directed self-checking bench for jtag_wb_master (TIMEOUT_CYCLES=16).
module tb_jtag_wb_master;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int CW = 3 + 4 + AW + DW;
   localparam int SW = 4 + DW;

   logic          sys_clk = 1'b0;
   logic          sys_rst_n = 1'b0;
   logic [CW-1:0] host_cmd = '0;
   logic [SW-1:0] host_sts;
   logic [AW-1:0] wb_adr;
   logic [DW-1:0] wb_dat_o, wb_dat_i = '0;
   logic [3:0]    wb_sel;
   logic          wb_we, wb_cyc, wb_stb;
   logic          wb_ack = 1'b0, wb_err = 1'b0;

   int total = 0;
   int bad = 0;

   int            lat, stb_n, n;
   logic          stable, cyc_after, busy_b, ack_mid, any_cyc;
   logic [AW-1:0] b_adr;
   logic [DW-1:0] b_dat;
   logic [3:0]    b_sel;
   logic          b_we;

   jtag_wb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .host_cmd_i (host_cmd),
      .host_sts_o (host_sts),
      .wb_adr_o   (wb_adr),
      .wb_dat_o   (wb_dat_o),
      .wb_dat_i   (wb_dat_i),
      .wb_sel_o   (wb_sel),
      .wb_we_o    (wb_we),
      .wb_cyc_o   (wb_cyc),
      .wb_stb_o   (wb_stb),
      .wb_ack_i   (wb_ack),
      .wb_err_i   (wb_err)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one command and act as slave: dly stb cycles pass before the response
   // (ak/er with read data rd) is driven; dly<0 keeps the slave silent.
   task automatic run(input logic t, input logic w, input logic i, input logic [3:0] s,
                      input logic [31:0] a, input logic [31:0] d, input int dly,
                      input logic ak, input logic er, input logic [31:0] rd);
      host_cmd = {t, w, i, s, a, d};
      wb_dat_i = rd;
      lat = 0;
      while (!wb_cyc && lat < 20) begin
         @(negedge sys_clk);
         lat++;
      end
      chk("cyc_start", wb_cyc, 1);
      b_adr = wb_adr;
      b_dat = wb_dat_o;
      b_sel = wb_sel;
      b_we = wb_we;
      busy_b = host_sts[DW+2];
      stable = 1'b1;
      stb_n = 1;
      while (1) begin
         if (dly >= 0 && stb_n == dly + 1) begin
            wb_ack = ak;
            wb_err = er;
         end
         @(negedge sys_clk);
         wb_ack = 1'b0;
         wb_err = 1'b0;
         if (!wb_stb || stb_n >= 40) break;
         stable &= (wb_adr === b_adr) && (wb_dat_o === b_dat) && (wb_sel === b_sel) && (wb_we === b_we) && wb_cyc;
         stb_n++;
      end
      cyc_after = wb_cyc;
      ack_mid = host_sts[DW+3];
      @(negedge sys_clk);
   endtask

   initial begin
      // reset state
      repeat (3) @(negedge sys_clk);
      chk("rst_sts", host_sts, 36'h0);
      chk("rst_cyc", {wb_cyc, wb_stb}, 2'b00);
      chk("rst_adr", wb_adr, 32'h0);
      sys_rst_n = 1'b1;
      repeat (6) @(negedge sys_clk);
      chk("idle_sts", host_sts, 36'h0);

      // single write, ack after 3 cycles
      run(1'b1, 1'b1, 1'b0, 4'hF, 32'h100, 32'hDEADBEEF, 3, 1'b1, 1'b0, 32'hAAAA5555);
      chk("wr_adr", b_adr, 32'h100);
      chk("wr_dat", b_dat, 32'hDEADBEEF);
      chk("wr_sel", b_sel, 4'hF);
      chk("wr_we", b_we, 1'b1);
      chk("wr_busy", busy_b, 1'b1);
      chk("wr_stb_cycles", stb_n, 4);
      chk("wr_stable", stable, 1'b1);
      chk("wr_cyc_after", cyc_after, 1'b0);
      chk("wr_ack_not_yet", ack_mid, 1'b0);
      chk("wr_sts", host_sts, 36'h8_0000_0000);

      // single read with sync + FSM latency
      run(1'b0, 1'b0, 1'b0, 4'hF, 32'h100, 32'h0, 0, 1'b1, 1'b0, 32'h12345678);
      chk("rd_latency", lat, 4);
      chk("rd_we", b_we, 1'b0);
      chk("rd_adr", b_adr, 32'h100);
      chk("rd_sts", host_sts, 36'h0_1234_5678);

      // auto-increment; the second one carries sel=0, still issued
      run(1'b1, 1'b0, 1'b0, 4'hF, 32'h200, 32'h0, 1, 1'b1, 1'b0, 32'h11111111);
      chk("inc0_adr", b_adr, 32'h200);
      run(1'b0, 1'b0, 1'b1, 4'h0, 32'h999, 32'h0, 1, 1'b1, 1'b0, 32'h22222222);
      chk("inc1_adr", b_adr, 32'h204);
      chk("inc1_sel0", b_sel, 4'h0);
      run(1'b1, 1'b0, 1'b1, 4'h3, 32'h999, 32'h0, 2, 1'b1, 1'b0, 32'h33333333);
      chk("inc2_adr", b_adr, 32'h208);
      chk("inc2_sts", host_sts, 36'h8_3333_3333);

      // address wrap
      run(1'b0, 1'b0, 1'b0, 4'hF, 32'hFFFFFFF8, 32'h0, 0, 1'b1, 1'b0, 32'h0);
      chk("wrap0_adr", b_adr, 32'hFFFFFFF8);
      run(1'b1, 1'b0, 1'b1, 4'hF, 32'h0, 32'h0, 0, 1'b1, 1'b0, 32'h0);
      chk("wrap1_adr", b_adr, 32'hFFFFFFFC);
      run(1'b0, 1'b0, 1'b1, 4'hF, 32'h0, 32'h0, 0, 1'b1, 1'b0, 32'h44444444);
      chk("wrap2_adr", b_adr, 32'h0);

      // err together with ack: err wins
      run(1'b1, 1'b0, 1'b0, 4'hF, 32'h500, 32'h0, 1, 1'b1, 1'b1, 32'h55555555);
      chk("errack_cyc_after", cyc_after, 1'b0);
      chk("errack_sts", host_sts, 36'hA_0000_0000);
      run(1'b0, 1'b0, 1'b0, 4'hF, 32'h504, 32'h0, 0, 1'b0, 1'b1, 32'h66666666);
      chk("err_sts", host_sts, 36'h2_0000_0000);

      // timeout with a silent slave
      run(1'b1, 1'b0, 1'b0, 4'hF, 32'h600, 32'h0, -1, 1'b0, 1'b0, 32'h77777777);
      chk("tmo_stb_cycles", stb_n, 16);
      chk("tmo_sts", host_sts, 36'h9_0000_0000);
      // ack on the expiry cycle wins over timeout
      run(1'b0, 1'b0, 1'b0, 4'hF, 32'h604, 32'h0, 15, 1'b1, 1'b0, 32'h88888888);
      chk("lateack_stb_cycles", stb_n, 16);
      chk("lateack_sts", host_sts, 36'h0_8888_8888);

      // async reset during BUS with tgl held high
      host_cmd = {1'b1, 1'b0, 1'b0, 4'hF, 32'h400, 32'h0};
      n = 0;
      while (!wb_cyc && n < 20) begin
         @(negedge sys_clk);
         n++;
      end
      chk("rst_bus_cyc", wb_cyc, 1'b1);
      @(negedge sys_clk);
      #2 sys_rst_n = 1'b0;
      #1;
      chk("rst_async_cyc", {wb_cyc, wb_stb}, 2'b00);
      chk("rst_async_sts", host_sts, 36'h0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      any_cyc = 1'b0;
      repeat (12) begin
         @(negedge sys_clk);
         any_cyc |= wb_cyc;
      end
      chk("rst_no_stale_cycle", any_cyc, 1'b0);
      chk("rst_resync_sts", host_sts, 36'h8_0000_0000);

      // next_adr cleared by reset: inc goes to 0
      run(1'b0, 1'b0, 1'b1, 4'hF, 32'h300, 32'h0, 0, 1'b1, 1'b0, 32'hCAFEF00D);
      chk("post_rst_adr", b_adr, 32'h0);
      chk("post_rst_sts", host_sts, 36'h0_CAFE_F00D);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
